// File: rtl/gps_srq_snapshot_if.sv
// Request, load/shift control and serial read path between the CPU side
// and the GPS service-request/snapshot block.
interface gps_srq_snapshot_if #(
  parameter int NCHAN  = 12,
  parameter int TICK_W = 48,
  parameter int REPL_W = 10
);
  localparam int CHAN_W = $clog2(NCHAN + 1);

  logic [NCHAN-1:0]        chan_srq;
  logic                    host_srq;
  logic                    mask_wr;
  logic [NCHAN-1:0]        mask_din;
  logic [TICK_W-1:0]       ticks;
  logic [NCHAN*REPL_W-1:0] replicas;
  logic                    ld_srq;
  logic                    ld_snap;
  logic                    ld_ovr;
  logic                    shift;
  logic                    ser;
  logic [CHAN_W-1:0]       next_chan;
  logic                    next_valid;

  modport master (
    output chan_srq, host_srq, mask_wr, mask_din, ticks, replicas,
           ld_srq, ld_snap, ld_ovr, shift,
    input  ser, next_chan, next_valid
  );

  modport slave (
    input  chan_srq, host_srq, mask_wr, mask_din, ticks, replicas,
           ld_srq, ld_snap, ld_ovr, shift,
    output ser, next_chan, next_valid
  );
endinterface

// File: rtl/gps_srq_snapshot.sv
// Service-request accumulator, overrun counters and snapshot capture for the
// GPS channel bank, serialised MSB-first onto the CPU read path.
module gps_srq_snapshot #(
  parameter int NCHAN  = 12,
  parameter int TICK_W = 48,
  parameter int REPL_W = 10,
  parameter int OVR_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gps_srq_snapshot_if.slave    bus
);
  localparam int SRQ_W  = NCHAN + 1;
  localparam int SNAP_W = TICK_W + NCHAN + NCHAN * REPL_W;
  localparam int OVR_FW = NCHAN * OVR_W;
  localparam int CHAN_W = $clog2(NCHAN + 1);

  typedef enum logic [1:0] {SEL_SRQ = 2'd0, SEL_SNAP = 2'd1, SEL_OVR = 2'd2} sel_t;

  sel_t              r_sel;
  logic [NCHAN:0]    r_noted;
  logic [NCHAN-1:0]  r_mask;
  logic [OVR_FW-1:0] r_ovr;
  logic [SRQ_W-1:0]  r_sh_srq;
  logic [SNAP_W-1:0] r_sh_snap;
  logic [OVR_FW-1:0] r_sh_ovr;
  logic [CHAN_W-1:0] r_next_chan;
  logic              r_next_vld;

  logic [NCHAN:0]    w_flags;
  logic              w_do_snap, w_do_srq, w_do_ovr;
  logic [SRQ_W-1:0]  w_srq_frame;
  logic [NCHAN-1:0]  w_pending;
  logic [SNAP_W-1:0] w_snap_frame;
  logic [NCHAN-1:0]  w_inc;
  logic [OVR_FW-1:0] w_ovr_nxt;
  logic              w_enc_vld;
  logic [CHAN_W-1:0] w_enc_idx;
  logic              w_ser;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_flags = {bus.host_srq, bus.chan_srq};

  // Only the winning load acts; the losers leave noted and counters alone.
  assign w_do_snap = bus.ld_snap;
  assign w_do_srq  = bus.ld_srq & ~bus.ld_snap;
  assign w_do_ovr  = bus.ld_ovr & ~bus.ld_snap & ~bus.ld_srq;

  assign w_srq_frame  = r_noted & {1'b1, r_mask};
  assign w_pending    = bus.chan_srq | r_noted[NCHAN-1:0];
  assign w_snap_frame = {bus.ticks, w_pending, bus.replicas};
  assign w_inc        = bus.chan_srq & r_noted[NCHAN-1:0] & {NCHAN{~w_do_srq}};

  always_comb begin
    w_ovr_nxt = r_ovr;
    for (int c = 0; c < NCHAN; c++) begin
      if (w_do_ovr)
        w_ovr_nxt[c*OVR_W +: OVR_W] = w_inc[c] ? OVR_W'(1) : '0;
      else if (w_inc[c])
        w_ovr_nxt[c*OVR_W +: OVR_W] = sat_inc(r_ovr[c*OVR_W +: OVR_W]);
    end
  end

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    w_enc_vld = 1'b0;
    w_enc_idx = '0;
    for (int i = NCHAN; i >= 0; i--) begin
      if (w_srq_frame[i]) begin
        w_enc_vld = 1'b1;
        w_enc_idx = CHAN_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= SEL_SRQ;
      r_noted     <= '0;
      r_mask      <= '0;
      r_ovr       <= '0;
      r_sh_srq    <= '0;
      r_sh_snap   <= '0;
      r_sh_ovr    <= '0;
      r_next_chan <= '0;
      r_next_vld  <= 1'b0;
    end else begin
      r_noted     <= w_do_srq ? w_flags : (r_noted | w_flags);
      r_ovr       <= w_ovr_nxt;
      r_next_vld  <= w_enc_vld;
      r_next_chan <= w_enc_idx;
      if (bus.mask_wr) r_mask <= bus.mask_din;

      if (w_do_snap) begin
        r_sel     <= SEL_SNAP;
        r_sh_snap <= w_snap_frame;
      end else if (w_do_srq) begin
        r_sel    <= SEL_SRQ;
        r_sh_srq <= w_srq_frame;
      end else if (w_do_ovr) begin
        r_sel    <= SEL_OVR;
        r_sh_ovr <= r_ovr;
      end else if (bus.shift) begin
        case (r_sel)
          SEL_SRQ:  r_sh_srq  <= r_sh_srq << 1;
          SEL_SNAP: r_sh_snap <= r_sh_snap << 1;
          SEL_OVR:  r_sh_ovr  <= r_sh_ovr << 1;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    w_ser = 1'b0;
    case (r_sel)
      SEL_SRQ:  w_ser = r_sh_srq[SRQ_W-1];
      SEL_SNAP: w_ser = r_sh_snap[SNAP_W-1];
      SEL_OVR:  w_ser = r_sh_ovr[OVR_FW-1];
      default:  w_ser = 1'b0;
    endcase
  end

  assign bus.ser        = w_ser;
  assign bus.next_chan  = r_next_chan;
  assign bus.next_valid = r_next_vld;
endmodule

// File: tb/tb_gps_srq_snapshot.sv
// Randomised and directed bench for gps_srq_snapshot against a queue-based
// reference model of the request, overrun and frame rules.
module tb_gps_srq_snapshot;
  localparam int NCHAN   = 12;
  localparam int TICK_W  = 48;
  localparam int REPL_W  = 10;
  localparam int OVR_W   = 4;
  localparam int SNAP_W  = TICK_W + NCHAN + NCHAN * REPL_W;
  localparam int OVR_FW  = NCHAN * OVR_W;
  localparam int OVR_MAX = (1 << OVR_W) - 1;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  gps_srq_snapshot_if #(.NCHAN(NCHAN), .TICK_W(TICK_W), .REPL_W(REPL_W)) bus();

  gps_srq_snapshot #(.NCHAN(NCHAN), .TICK_W(TICK_W), .REPL_W(REPL_W), .OVR_W(OVR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit m_noted [NCHAN+1];
  bit m_mask  [NCHAN];
  int m_ovr   [NCHAN];
  bit m_q[$];
  bit m_vld;
  int m_chan;

  task automatic model_reset();
    for (int c = 0; c <= NCHAN; c++) m_noted[c] = 1'b0;
    for (int c = 0; c < NCHAN; c++) begin m_mask[c] = 1'b0; m_ovr[c] = 0; end
    m_q.delete();
    m_vld = 1'b0;
    m_chan = 0;
  endtask

  task automatic model_edge();
    bit win_snap, win_srq, win_ovr, nv, inc;
    int nc;
    win_snap = bus.ld_snap;
    win_srq  = bus.ld_srq && !bus.ld_snap;
    win_ovr  = bus.ld_ovr && !bus.ld_snap && !bus.ld_srq;
    nv = 1'b0; nc = 0;
    for (int c = 0; c < NCHAN; c++)
      if (!nv && m_noted[c] && m_mask[c]) begin nv = 1'b1; nc = c; end
    if (!nv && m_noted[NCHAN]) begin nv = 1'b1; nc = NCHAN; end
    if (win_snap) begin
      m_q.delete();
      for (int b = TICK_W-1; b >= 0; b--) m_q.push_back(bus.ticks[b]);
      for (int c = NCHAN-1; c >= 0; c--) m_q.push_back(bus.chan_srq[c] | m_noted[c]);
      for (int c = NCHAN-1; c >= 0; c--)
        for (int b = REPL_W-1; b >= 0; b--) m_q.push_back(bus.replicas[c*REPL_W+b]);
    end else if (win_srq) begin
      m_q.delete();
      m_q.push_back(m_noted[NCHAN]);
      for (int c = NCHAN-1; c >= 0; c--) m_q.push_back(m_noted[c] & m_mask[c]);
    end else if (win_ovr) begin
      m_q.delete();
      for (int c = NCHAN-1; c >= 0; c--)
        for (int b = OVR_W-1; b >= 0; b--) m_q.push_back(((m_ovr[c] >> b) & 1) != 0);
    end else if (bus.shift && m_q.size() > 0) begin
      void'(m_q.pop_front());
    end
    for (int c = 0; c < NCHAN; c++) begin
      inc = bus.chan_srq[c] && m_noted[c] && !win_srq;
      if (win_ovr) m_ovr[c] = inc ? 1 : 0;
      else if (inc && m_ovr[c] < OVR_MAX) m_ovr[c]++;
    end
    for (int c = 0; c <= NCHAN; c++) begin
      bit f;
      f = (c == NCHAN) ? bus.host_srq : bus.chan_srq[c];
      m_noted[c] = win_srq ? f : (m_noted[c] | f);
    end
    if (bus.mask_wr) for (int c = 0; c < NCHAN; c++) m_mask[c] = bus.mask_din[c];
    m_vld = nv;
    m_chan = nc;
  endtask

  function automatic bit exp_ser();
    return (m_q.size() > 0) ? m_q[0] : 1'b0;
  endfunction

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    v = '0;
    foreach (m_q[i]) v = {v[254:0], m_q[i]};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
  endtask

  task automatic idle();
    bus.chan_srq = '0; bus.host_srq = 1'b0; bus.mask_wr = 1'b0; bus.mask_din = '0;
    bus.ld_srq = 1'b0; bus.ld_snap = 1'b0; bus.ld_ovr = 1'b0; bus.shift = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic read_frame(input int n, output logic [255:0] v);
    v = '0;
    for (int k = 0; k < n; k++) begin
      v = {v[254:0], bus.ser};
      bus.shift = 1'b1;
      tick();
      bus.shift = 1'b0;
    end
  endtask

  task automatic set_mask(input logic [NCHAN-1:0] m);
    bus.mask_wr = 1'b1; bus.mask_din = m;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    bus.ticks = '0; bus.replicas = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++; if (bus.ser !== 1'b0) begin n_err++; $display("FAIL reset_ser got=%b exp=0", bus.ser); end
    n_chk++; if (bus.next_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.next_valid); end
    n_chk++; if (bus.next_chan !== '0) begin n_err++; $display("FAIL reset_chan got=%0d exp=0", bus.next_chan); end
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_srq_frame();
    logic [15:0] col;
    do_reset();
    set_mask('1);
    bus.chan_srq = NCHAN'(1) << 3;
    tick();
    idle();
    tick();
    n_chk++; if (bus.next_valid !== 1'b1 || bus.next_chan !== 4'd3) begin
      n_err++; $display("FAIL srq_enc got=%b/%0d exp=1/3", bus.next_valid, bus.next_chan); end
    bus.ld_srq = 1'b1;
    tick();
    idle();
    col = '0;
    for (int k = 0; k < 16; k++) begin
      n_chk++; if (bus.ser !== exp_ser()) begin
        n_err++; $display("FAIL srq_ser bit=%0d got=%b exp=%b", k, bus.ser, exp_ser()); end
      if (k == 1) begin
        n_chk++; if (bus.next_valid !== 1'b0) begin
          n_err++; $display("FAIL srq_valid_clear got=%b exp=0", bus.next_valid); end
      end
      col[15-k] = bus.ser;
      bus.shift = 1'b1;
      tick();
      bus.shift = 1'b0;
    end
    n_chk++; if (col !== 16'h0040) begin n_err++; $display("FAIL srq_seq got=%h exp=0040", col); end
  endtask

  task automatic test_overrun();
    logic [255:0] got, exp;
    logic [OVR_W-1:0] req [3];
    req[0] = 4'd2; req[1] = 4'd0; req[2] = 4'd15;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      int np;
      np = (r == 0) ? 3 : (r == 2) ? 17 : 0;
      for (int i = 0; i < np; i++) begin
        bus.chan_srq = NCHAN'(1) << 5;
        tick();
        idle();
        tick();
      end
      bus.ld_ovr = 1'b1;
      tick();
      idle();
      exp = model_vec();
      read_frame(OVR_FW, got);
      n_chk++; if (got !== exp) begin n_err++; $display("FAIL ovr_frame%0d got=%h exp=%h", r, got, exp); end
      n_chk++; if (got[5*OVR_W +: OVR_W] !== req[r]) begin
        n_err++; $display("FAIL ovr_ch5_%0d got=%0d exp=%0d", r, got[5*OVR_W +: OVR_W], req[r]); end
    end
  endtask

  task automatic test_snapshot();
    logic [255:0] got, exp, e;
    do_reset();
    bus.ticks = 48'h0123456789AB;
    e = '0;
    e[SNAP_W-1 -: TICK_W] = 48'h0123456789AB;
    for (int c = 0; c < NCHAN; c++) begin
      bus.replicas[c*REPL_W +: REPL_W] = REPL_W'(c);
      e[c*REPL_W +: REPL_W] = REPL_W'(c);
    end
    bus.ld_snap = 1'b1;
    tick();
    idle();
    exp = model_vec();
    read_frame(SNAP_W, got);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL snap_model got=%h exp=%h", got, exp); end
    n_chk++; if (got !== e) begin n_err++; $display("FAIL snap_const got=%h exp=%h", got, e); end
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (bus.ser !== 1'b0) begin n_err++; $display("FAIL snap_past_end got=%b exp=0", bus.ser); end
      bus.shift = 1'b1;
      tick();
      bus.shift = 1'b0;
    end
  endtask

  task automatic test_coincident();
    logic [255:0] got;
    logic exp_b0 [3];
    exp_b0[0] = 1'b0; exp_b0[1] = 1'b1; exp_b0[2] = 1'b1;
    do_reset();
    set_mask('1);
    for (int r = 0; r < 3; r++) begin
      if (r == 2) begin
        bus.chan_srq = NCHAN'(1);
        tick();
        idle();
      end
      bus.ld_srq = 1'b1;
      bus.chan_srq = (r == 1) ? '0 : NCHAN'(1);
      tick();
      idle();
      read_frame(NCHAN + 1, got);
      n_chk++; if (got[0] !== exp_b0[r]) begin
        n_err++; $display("FAIL coinc_bit0_%0d got=%b exp=%b", r, got[0], exp_b0[r]); end
    end
    bus.ld_ovr = 1'b1;
    tick();
    idle();
    read_frame(OVR_FW, got);
    n_chk++; if (got !== '0) begin n_err++; $display("FAIL coinc_no_ovr got=%h exp=0", got); end
  endtask

  task automatic test_simul_mask();
    logic [255:0] got, exp;
    do_reset();
    set_mask('1);
    bus.chan_srq = NCHAN'(1) << 2;
    tick();
    idle();
    bus.ld_snap = 1'b1; bus.ld_srq = 1'b1;
    tick();
    idle();
    exp = model_vec();
    read_frame(SNAP_W, got);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL simul_snap got=%h exp=%h", got, exp); end
    n_chk++; if (got[NCHAN*REPL_W + 2] !== 1'b1) begin
      n_err++; $display("FAIL simul_pending2 got=%b exp=1", got[NCHAN*REPL_W + 2]); end
    bus.ld_srq = 1'b1;
    tick();
    idle();
    read_frame(NCHAN + 1, got);
    n_chk++; if (got[2] !== 1'b1) begin n_err++; $display("FAIL simul_noted_kept got=%b exp=1", got[2]); end
    set_mask(~(NCHAN'(1) << 3));
    bus.chan_srq = (NCHAN'(1) << 3) | (NCHAN'(1) << 7);
    tick();
    idle();
    tick();
    n_chk++; if (bus.next_valid !== 1'b1 || bus.next_chan !== 4'd7) begin
      n_err++; $display("FAIL mask_enc got=%b/%0d exp=1/7", bus.next_valid, bus.next_chan); end
  endtask

  task automatic test_random();
    do_reset();
    set_mask(NCHAN'($urandom));
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCHAN; c++) bus.chan_srq[c] = ($urandom_range(7) == 0);
      bus.host_srq = ($urandom_range(15) == 0);
      bus.mask_wr  = ($urandom_range(63) == 0);
      bus.mask_din = NCHAN'($urandom);
      bus.ticks    = {16'($urandom), $urandom};
      for (int c = 0; c < NCHAN; c++) bus.replicas[c*REPL_W +: REPL_W] = REPL_W'($urandom);
      bus.ld_srq  = ($urandom_range(15) == 0);
      bus.ld_snap = ($urandom_range(15) == 0);
      bus.ld_ovr  = ($urandom_range(15) == 0);
      bus.shift   = ($urandom_range(1) == 0);
      tick();
      n_chk++; if (bus.ser !== exp_ser()) begin
        n_err++; $display("FAIL rand_ser cyc=%0d got=%b exp=%b", i, bus.ser, exp_ser()); end
      n_chk++; if (bus.next_valid !== m_vld) begin
        n_err++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, bus.next_valid, m_vld); end
      n_chk++; if (int'(bus.next_chan) != m_chan) begin
        n_err++; $display("FAIL rand_chan cyc=%0d got=%0d exp=%0d", i, bus.next_chan, m_chan); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    logic [255:0] got, exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.chan_srq = NCHAN'(2);
      tick();
      idle();
    end
    bus.ticks = '1;
    bus.ld_snap = 1'b1;
    tick();
    idle();
    bus.shift = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.shift = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.ser !== 1'b0) begin n_err++; $display("FAIL async_ser got=%b exp=0", bus.ser); end
    n_chk++; if (bus.next_valid !== 1'b0 || bus.next_chan !== '0) begin
      n_err++; $display("FAIL async_enc got=%b/%0d exp=0/0", bus.next_valid, bus.next_chan); end
    model_reset();
    tick();
    #2 rst_n = 1'b1;
    bus.ld_ovr = 1'b1;
    tick();
    idle();
    exp = model_vec();
    read_frame(OVR_FW, got);
    n_chk++; if (got !== '0 || got !== exp) begin
      n_err++; $display("FAIL async_ovr_clear got=%h exp=0", got); end
  endtask

  initial begin
    test_reset();
    test_srq_frame();
    test_overrun();
    test_snapshot();
    test_coincident();
    test_simul_mask();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/gps_srq_snapshot.md
# gps_srq_snapshot

Parametrised service-request and snapshot serialiser for the GPS channel bank. It accumulates per-channel epoch requests plus the host request, and captures atomic snapshots of the tick counter, pending flags and per-channel clock replicas. All frames are shifted out one bit at a time on the CPU's serial read path. Compared with the fixed-size predecessor it adds:
- a configurable channel count and field widths;
- per-channel saturating overrun counters, read-and-clear;
- a registered priority encoder that names the next channel to service.

## Interface
- NCHAN, 12: number of demodulator channels (1..32)
- TICK_W, 48: width of the tick counter field
- REPL_W, 10: width of each channel's clock-replica field
- OVR_W, 4: width of each overrun counter
- clk  in  1  system clock; all logic single-clock
- rst_n  in  1  reset, asynchronous assert, active-low
- chan_srq  in  NCHAN  per-channel epoch pulses, one cycle each
- host_srq  in  1  host request level/pulse
- mask_wr  in  1  load channel mask
- mask_din  in  NCHAN  new mask value
- ticks  in  TICK_W  tick count, already synchronised to clk
- replicas  in  NCHAN*REPL_W  channel c occupies [c*REPL_W +: REPL_W]
- ld_srq  in  1  capture SRQ frame and clear noted flags
- ld_snap  in  1  capture snapshot frame
- ld_ovr  in  1  capture overrun frame and clear counters
- shift  in  1  advance selected frame by one bit
- ser  out  1  serial data, MSB-first, of the last-loaded frame
- next_chan  out  $clog2(NCHAN+1)  lowest-index pending masked channel; NCHAN means host
- next_valid  out  1  next_chan is meaningful

## Operation
- noted[NCHAN:0] is sticky: noted <= flags | noted, where flags = {host_srq, chan_srq}.
  - On ld_srq: noted <= flags, so a request arriving in the load cycle is kept for the next frame.
- SRQ frame, NCHAN+1 bits: noted & {1'b1, mask} taken before the clear. Host is the first bit out, then channel NCHAN-1 down to 0.
- Snapshot frame, TICK_W+NCHAN+NCHAN*REPL_W bits, in order:
  - ticks;
  - pending = chan_srq | noted[NCHAN-1:0];
  - replicas, highest channel first.
- Overrun: when chan_srq[c]=1 while noted[c]=1 and ld_srq=0, ovr[c] increments.
  - ovr[c] saturates at 2^OVR_W-1.
  - Overrun frame: NCHAN*OVR_W bits, channel NCHAN-1 first.
  - On ld_ovr the counters are captured, then cleared.
  - If an increment coincides with ld_ovr: the frame holds the old value and ovr[c] <= 1.
- Frame select register sel ∈ {SRQ, SNAP, OVR} is set by whichever load fires.
  - Simultaneous loads: priority ld_snap > ld_srq > ld_ovr. Only the winning frame is captured.
  - Losing loads have no side effects: no noted clear, no counter clear.
- Each frame has its own shift register.
  - shift advances only the register named by sel, left by one with zero fill.
  - A load in the same cycle as shift wins; no shift occurs that cycle.
  - Shifting past the frame end yields ser=0 indefinitely.
- ser = MSB of the selected shift register.
- Priority encoder: lowest set index of noted & {1'b1, mask}.
  - Channels 0..NCHAN-1 rank first; host (index NCHAN) ranks last.
  - next_valid=0 and next_chan=0 when nothing is pending.
- mask_wr updates mask the next edge. It affects frames loaded afterwards, never a frame already captured.

## Timing
- Reset (rst_n=0, asynchronous): noted, mask, ovr, sel=SRQ, all shift registers, next_chan and next_valid all 0, so ser=0.
  - Reset deasserted mid-frame: the frame is discarded.
- Load in cycle N: ser shows the frame's first bit from N+1.
- Each shift in cycle M: ser shows the next bit from M+1.
  - Back-to-back shifts give one bit per cycle.
- chan_srq in cycle N:
  - noted set at N+1;
  - next_chan/next_valid reflect it at N+2 (registered encoder);
  - visible in a frame loaded at N+1 or later.
- A request pulse in the same cycle as ld_srq is not in that frame; it appears in the next one.
- Overrun increments register at N+1.

## Test plan
- Reset, then NCHAN=12, mask=12'hFFF, pulse chan_srq[3], ld_srq, 13 shifts -> ser sequence: 0 (host), eight 0s, 1, then three 0s; 14th shift onward -> 0; next_valid=1, next_chan=3 before the load, next_valid=0 two cycles after it.
- Pulse chan_srq[5] three times with no ld_srq, then ld_ovr -> channel 5's field reads 2; a second ld_ovr reads 0. Seventeen further repeat pulses -> field saturates at 15.
- ticks=48'h0123456789AB, replicas channel c = c, ld_snap, shift the full frame -> bits match {ticks, pending, replicas 11..0} exactly.
- ld_srq coincident with chan_srq[0] -> current frame bit 0 = 0; a following ld_srq frame bit 0 = 1; no overrun counted.
- ld_snap and ld_srq in the same cycle -> snapshot served; noted not cleared. Mask channel 3 off, pend 3 and 7 -> next_chan=7.
- Assert rst_n low mid-shift of a snapshot -> ser=0 immediately (asynchronous); all counters 0.
